// File: rtl/traffic_cmd_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package  : traffic_cmd_pkg                                           |
// | Purpose  : Command codes, data width and arbiter FSM states shared   |
// |            between traffic_lights, its command arbiter and benches.  |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package traffic_cmd_pkg;

   localparam int TL_DATA_W = 16;

   typedef enum logic [2:0] {
      CMD_ON         = 3'b000,
      CMD_OFF        = 3'b001,
      CMD_NOTRANS    = 3'b010,
      CMD_SET_GREEN  = 3'b011,
      CMD_SET_RED    = 3'b100,
      CMD_SET_YELLOW = 3'b101
   } cmd_type_t;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      S_NOTRANS = 3'd1,
      S_GREEN   = 3'd2,
      S_RED     = 3'd3,
      S_YELLOW  = 3'd4,
      S_ON      = 3'd5,
      S_OFF     = 3'd6,
      GAP       = 3'd7
   } tl_arb_state_t;

   // Command code driven while the FSM sits in a given state (0 when silent)
   function automatic cmd_type_t state_cmd(input tl_arb_state_t st);
      case (st)
         S_NOTRANS: state_cmd = CMD_NOTRANS;
         S_GREEN:   state_cmd = CMD_SET_GREEN;
         S_RED:     state_cmd = CMD_SET_RED;
         S_YELLOW:  state_cmd = CMD_SET_YELLOW;
         S_OFF:     state_cmd = CMD_OFF;
         default:   state_cmd = CMD_ON;
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : rr_arbiter                                                |
// | Purpose  : Combinational round-robin pick: first asserted request at |
// |            or after the pointer, wrapping. Pointer kept by parent.   |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module rr_arbiter #(
   parameter int N = 4
) (
   input  logic [N-1:0]         req_i,
   input  logic [$clog2(N)-1:0] ptr_i,
   output logic [N-1:0]         gnt_o,
   output logic [$clog2(N)-1:0] idx_o,
   output logic                 any_o
);

   localparam int IW = $clog2(N);

   logic [IW:0]   w_sum;
   logic [IW-1:0] w_pos;
   logic          w_found;

   // Walk N positions starting at the pointer; the first hit wins
   always_comb begin
      gnt_o   = '0;
      idx_o   = '0;
      w_found = 1'b0;
      w_sum   = '0;
      w_pos   = '0;
      for (int k = 0; k < N; k++) begin
         w_sum = {1'b0, ptr_i} + (IW+1)'(k);
         if (w_sum >= (IW+1)'(N)) begin
            w_sum = w_sum - (IW+1)'(N);
         end
         w_pos = w_sum[IW-1:0];
         if (!w_found && req_i[w_pos]) begin
            w_found      = 1'b1;
            gnt_o[w_pos] = 1'b1;
            idx_o        = w_pos;
         end
      end
      any_o = w_found;
   end

endmodule
`default_nettype wire

// File: rtl/traffic_cmd_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : traffic_cmd_arbiter                                       |
// | Purpose  : Round-robin sharing of the traffic_lights command port;   |
// |            each granted transaction is replayed as a fixed burst.    |
// | Options  : TL_CMD_ZERO_REJECT_EN - reject config with a zero time.   |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module traffic_cmd_arbiter
   import traffic_cmd_pkg::*;
#(
   parameter int N_REQ      = 4,
   parameter int DATA_W     = TL_DATA_W,
   parameter int GAP_CYCLES = 2
) (
   input  logic                           clk_i,
   input  logic                           arstn_i,
   input  logic [N_REQ-1:0]               req_valid_i,
   output logic [N_REQ-1:0]               req_ready_o,
   input  logic [N_REQ-1:0]               req_off_i,
   input  logic [N_REQ-1:0][DATA_W-1:0]   req_green_ms_i,
   input  logic [N_REQ-1:0][DATA_W-1:0]   req_red_ms_i,
   input  logic [N_REQ-1:0][DATA_W-1:0]   req_yellow_ms_i,
   output logic [2:0]                     cmd_type_o,
   output logic                           cmd_valid_o,
   output logic [DATA_W-1:0]              cmd_data_o,
   output logic                           busy_o,
   output logic [$clog2(N_REQ)-1:0]       grant_id_o,
   output logic                           err_o
);

   localparam int            IW         = $clog2(N_REQ);
   localparam int            CW         = $clog2(GAP_CYCLES + 1);
   localparam logic [CW-1:0] c_gap_last = CW'(GAP_CYCLES - 1);
   localparam logic [IW-1:0] c_last_req = IW'(N_REQ - 1);

   tl_arb_state_t     r_state;
   tl_arb_state_t     w_state_nxt;
   logic [IW-1:0]     r_ptr;
   logic [IW-1:0]     r_gid;
   logic [DATA_W-1:0] r_green;
   logic [DATA_W-1:0] r_red;
   logic [DATA_W-1:0] r_yellow;
   logic [CW-1:0]     r_gap_cnt;
   logic              r_cmd_valid;
   cmd_type_t         r_cmd_type;
   logic [DATA_W-1:0] r_cmd_data;
   logic              w_cmd_valid_nxt;
   logic [DATA_W-1:0] w_cmd_data_nxt;

   logic [N_REQ-1:0]  w_gnt;
   logic [IW-1:0]     w_idx;
   logic              w_any;
   logic              w_grant;

   rr_arbiter #(.N(N_REQ)) u_rr (
      .req_i (req_valid_i),
      .ptr_i (r_ptr),
      .gnt_o (w_gnt),
      .idx_o (w_idx),
      .any_o (w_any)
   );

   // Grants only happen in IDLE and never while reset is applied
   assign w_grant     = w_any && (r_state == IDLE) && arstn_i;
   assign req_ready_o = w_gnt & {N_REQ{w_grant}};
   assign busy_o      = (r_state != IDLE);
   assign grant_id_o  = r_gid;
   assign cmd_valid_o = r_cmd_valid;
   assign cmd_type_o  = r_cmd_type;
   assign cmd_data_o  = r_cmd_data;

`ifdef TL_CMD_ZERO_REJECT_EN
   logic r_err;
   logic w_err_nxt;
   logic w_zero;

   // A config request with any zero time field is accepted but not issued
   assign w_zero = !req_off_i[w_idx] &&
                   ((req_green_ms_i[w_idx] == '0) ||
                    (req_red_ms_i[w_idx]   == '0) ||
                    (req_yellow_ms_i[w_idx] == '0));
   assign err_o  = r_err;
`else
   assign err_o  = 1'b0;
`endif

   // Next-state and next-output decode; outputs are registered from next state
   always_comb begin
      w_state_nxt = r_state;
`ifdef TL_CMD_ZERO_REJECT_EN
      w_err_nxt   = 1'b0;
`endif
      unique case (r_state)
         IDLE: begin
            if (w_grant) begin
               if (req_off_i[w_idx]) begin
                  w_state_nxt = S_OFF;
               end
`ifdef TL_CMD_ZERO_REJECT_EN
               else if (w_zero) begin
                  w_state_nxt = GAP;
                  w_err_nxt   = 1'b1;
               end
`endif
               else begin
                  w_state_nxt = S_NOTRANS;
               end
            end
         end
         S_NOTRANS: w_state_nxt = S_GREEN;
         S_GREEN:   w_state_nxt = S_RED;
         S_RED:     w_state_nxt = S_YELLOW;
         S_YELLOW:  w_state_nxt = S_ON;
         S_ON:      w_state_nxt = GAP;
         S_OFF:     w_state_nxt = GAP;
         GAP: begin
            if (r_gap_cnt == '0) begin
               w_state_nxt = IDLE;
            end
         end
         default:   w_state_nxt = IDLE;
      endcase

      w_cmd_valid_nxt = (w_state_nxt != IDLE) && (w_state_nxt != GAP);
      case (w_state_nxt)
         S_GREEN:  w_cmd_data_nxt = r_green;
         S_RED:    w_cmd_data_nxt = r_red;
         S_YELLOW: w_cmd_data_nxt = r_yellow;
         default:  w_cmd_data_nxt = '0;
      endcase
   end

   // FSM state register
   always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Grant bookkeeping: pointer advance, grant id and field capture
   always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) begin
         r_ptr    <= '0;
         r_gid    <= '0;
         r_green  <= '0;
         r_red    <= '0;
         r_yellow <= '0;
      end else if (w_grant) begin
         r_ptr    <= (w_idx == c_last_req) ? '0 : w_idx + 1'b1;
         r_gid    <= w_idx;
         r_green  <= req_green_ms_i[w_idx];
         r_red    <= req_red_ms_i[w_idx];
         r_yellow <= req_yellow_ms_i[w_idx];
      end
   end

   // Gap length counter, loaded on GAP entry and counted down to zero
   always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) begin
         r_gap_cnt <= '0;
      end else if ((w_state_nxt == GAP) && (r_state != GAP)) begin
         r_gap_cnt <= c_gap_last;
      end else if ((r_state == GAP) && (r_gap_cnt != '0)) begin
         r_gap_cnt <= r_gap_cnt - 1'b1;
      end
   end

   // Registered command outputs
   always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) begin
         r_cmd_valid <= 1'b0;
         r_cmd_type  <= CMD_ON;
         r_cmd_data  <= '0;
      end else begin
         r_cmd_valid <= w_cmd_valid_nxt;
         r_cmd_type  <= state_cmd(w_state_nxt);
         r_cmd_data  <= w_cmd_data_nxt;
      end
   end

`ifdef TL_CMD_ZERO_REJECT_EN
   // One-cycle rejection pulse
   always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) begin
         r_err <= 1'b0;
      end else begin
         r_err <= w_err_nxt;
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_traffic_cmd_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_traffic_cmd_arbiter                                    |
// | Purpose  : Self-checking bench for traffic_cmd_arbiter with a        |
// |            timeline-based reference model and directed pin checks.   |
// | Options  : TL_CMD_ZERO_REJECT_EN - must match the RTL build.         |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_traffic_cmd_arbiter;
   import traffic_cmd_pkg::*;

   localparam int N   = 4;
   localparam int DW  = 16;
   localparam int GAP = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                 arstn_i;
   logic [N-1:0]         req_valid, req_ready, req_off;
   logic [N-1:0][DW-1:0] req_g, req_r, req_y;
   logic [2:0]           cmd_type;
   logic                 cmd_valid;
   logic [DW-1:0]        cmd_data;
   logic                 busy;
   logic [1:0]           gid;
   logic                 err;

   traffic_cmd_arbiter #(.N_REQ(N), .DATA_W(DW), .GAP_CYCLES(GAP)) dut (
      .clk_i           (clk),
      .arstn_i         (arstn_i),
      .req_valid_i     (req_valid),
      .req_ready_o     (req_ready),
      .req_off_i       (req_off),
      .req_green_ms_i  (req_g),
      .req_red_ms_i    (req_r),
      .req_yellow_ms_i (req_y),
      .cmd_type_o      (cmd_type),
      .cmd_valid_o     (cmd_valid),
      .cmd_data_o      (cmd_data),
      .busy_o          (busy),
      .grant_id_o      (gid),
      .err_o           (err)
   );

   // Drive shadows, copied onto the DUT inputs at each falling edge
   logic                 drv_arstn;
   logic [N-1:0]         drv_valid, drv_off;
   logic [N-1:0][DW-1:0] drv_g, drv_r, drv_y;

   typedef struct {
      logic          v;
      logic [2:0]    t;
      logic [DW-1:0] d;
      logic          e;
   } ev_t;

   ev_t      sched[$];
   int       mptr, mgid, cyc;
   bit [N-1:0] acc;
   bit       rnd_en, keep_valid;
   int       total = 0;
   int       bad   = 0;

   function automatic void chk(string name, int unsigned act, int unsigned exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   function automatic ev_t mk(logic v, logic [2:0] t, logic [DW-1:0] d, logic e);
      ev_t x;
      x.v = v; x.t = t; x.d = d; x.e = e;
      return x;
   endfunction

   function automatic logic [DW-1:0] rnd_field();
      if ($urandom_range(0, 7) == 0) return '0;
      return DW'($urandom_range(1, 65535));
   endfunction

   function automatic void new_req(int i);
      drv_valid[i] = 1'b1;
      drv_off[i]   = ($urandom_range(0, 4) == 0);
      drv_g[i]     = rnd_field();
      drv_r[i]     = rnd_field();
      drv_y[i]     = rnd_field();
   endfunction

   function automatic void set_req(int i, logic off, int g, int r, int y);
      drv_valid[i] = 1'b1;
      drv_off[i]   = off;
      drv_g[i]     = DW'(g);
      drv_r[i]     = DW'(r);
      drv_y[i]     = DW'(y);
   endfunction

   // One clock cycle: apply stimulus, compare against the model, advance the model
   task automatic step();
      ev_t        e;
      bit         idle;
      bit [N-1:0] er;
      int         g;
      bit         rej;
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
         if (acc[i]) begin
            if (rnd_en && $urandom_range(0, 1) == 0) new_req(i);
            else if (!keep_valid) drv_valid[i] = 1'b0;
         end else if (rnd_en) begin
            if (!drv_valid[i]) begin
               if ($urandom_range(0, 3) == 0) new_req(i);
            end else if ($urandom_range(0, 63) == 0) begin
               drv_valid[i] = 1'b0;
            end
         end
      end
      acc       = '0;
      arstn_i   = drv_arstn;
      req_valid = drv_valid;
      req_off   = drv_off;
      req_g     = drv_g;
      req_r     = drv_r;
      req_y     = drv_y;
      #1;
      e    = mk(1'b0, 3'd0, '0, 1'b0);
      idle = 1'b1;
      if (sched.size() > 0) begin
         e    = sched.pop_front();
         idle = 1'b0;
      end
      er = '0;
      g  = -1;
      if (idle && arstn_i) begin
         for (int k = 0; k < N; k++) begin
            int p;
            p = (mptr + k) % N;
            if (g < 0 && req_valid[p]) g = p;
         end
      end
      if (g >= 0) er[g] = 1'b1;
      chk("cmd_valid", cmd_valid, e.v);
      chk("cmd_type", cmd_type, e.t);
      chk("cmd_data", cmd_data, e.d);
      chk("err", err, e.e);
      chk("busy", busy, !idle);
      chk("grant_id", gid, mgid);
      chk("req_ready", req_ready, er);
      if (g >= 0) begin
         rej = 1'b0;
`ifdef TL_CMD_ZERO_REJECT_EN
         rej = !req_off[g] && (req_g[g] == 0 || req_r[g] == 0 || req_y[g] == 0);
`endif
         if (rej) begin
            for (int k = 0; k < GAP; k++) sched.push_back(mk(1'b0, 3'd0, '0, k == 0));
         end else begin
            if (req_off[g]) begin
               sched.push_back(mk(1'b1, 3'b001, '0, 1'b0));
            end else begin
               sched.push_back(mk(1'b1, 3'b010, '0, 1'b0));
               sched.push_back(mk(1'b1, 3'b011, req_g[g], 1'b0));
               sched.push_back(mk(1'b1, 3'b100, req_r[g], 1'b0));
               sched.push_back(mk(1'b1, 3'b101, req_y[g], 1'b0));
               sched.push_back(mk(1'b1, 3'b000, '0, 1'b0));
            end
            for (int k = 0; k < GAP; k++) sched.push_back(mk(1'b0, 3'd0, '0, 1'b0));
         end
         mgid = g;
         mptr = (g + 1) % N;
         acc  = er;
      end
      cyc++;
   endtask

   task automatic wait_grant(output int g, output int n);
      g = -1;
      n = 0;
      for (int k = 0; k < 40; k++) begin
         step();
         n++;
         if (acc != 0) begin
            for (int i = 0; i < N; i++) if (acc[i]) g = i;
            return;
         end
      end
      chk("grant_timeout", 0, 1);
   endtask

   task automatic drain();
      for (int k = 0; k < 80; k++) begin
         if (sched.size() == 0 && drv_valid == 0 && acc == 0) return;
         step();
      end
      chk("drain_timeout", 0, 1);
   endtask

   int exp_order[5] = '{0, 1, 2, 3, 0};
   int exp_t[5]     = '{2, 3, 4, 5, 0};
   int exp_d[5]     = '{0, 30, 50, 100, 0};

   initial begin
      int g, n;
      cyc = 0; mptr = 0; mgid = 0; acc = '0;
      rnd_en = 1'b0; keep_valid = 1'b0;
      drv_arstn = 1'b0; arstn_i = 1'b0;
      drv_valid = '0; drv_off = '0; drv_g = '0; drv_r = '0; drv_y = '0;
      req_valid = '0; req_off = '0; req_g = '0; req_r = '0; req_y = '0;

      // Reset with every requester already pending: nothing may be granted
      for (int i = 0; i < N; i++) set_req(i, 1'b0, 10 + i, 20 + i, 30 + i);
      repeat (3) step();
      chk("rst_cmd_valid", cmd_valid, 0);
      chk("rst_cmd_type", cmd_type, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ready", req_ready, 0);
      chk("rst_gid", gid, 0);

      // All requesters valid continuously: rotating order, fixed spacing
      drv_arstn  = 1'b1;
      keep_valid = 1'b1;
      for (int r = 0; r < 5; r++) begin
         wait_grant(g, n);
         chk("rr_order", g, exp_order[r]);
         if (r > 0) chk("rr_spacing", n + 1, 6 + GAP);
         step();
         chk("rr_gid", gid, exp_order[r]);
      end
      keep_valid = 1'b0;
      drv_valid  = '0;
      drain();

      // Single config request from requester 0
      set_req(0, 1'b0, 30, 50, 100);
      wait_grant(g, n);
      chk("single_grant", g, 0);
      for (int s = 0; s < 5; s++) begin
         step();
         chk("single_valid", cmd_valid, 1);
         chk("single_type", cmd_type, exp_t[s]);
         chk("single_data", cmd_data, exp_d[s]);
      end
      repeat (GAP) step();
      chk("single_busy_gap", busy, 1);
      step();
      chk("single_busy_done", busy, 0);

      // OFF request from requester 2, follow-up grant at t+4
      set_req(2, 1'b1, 5, 6, 7);
      wait_grant(g, n);
      chk("off_grant", g, 2);
      step();
      chk("off_valid", cmd_valid, 1);
      chk("off_type", cmd_type, 1);
      step();
      chk("off_quiet", cmd_valid, 0);
      set_req(0, 1'b0, 1, 2, 3);
      step();
      chk("off_no_early", req_ready, 0);
      step();
      chk("off_next_grant", req_ready, 1);
      drain();

      // Zero red time from requester 1
      set_req(1, 1'b0, 7, 0, 9);
      wait_grant(g, n);
      chk("zero_grant", g, 1);
`ifdef TL_CMD_ZERO_REJECT_EN
      step();
      chk("zero_err", err, 1);
      chk("zero_quiet1", cmd_valid, 0);
      step();
      chk("zero_err_off", err, 0);
      chk("zero_quiet2", cmd_valid, 0);
      step();
      chk("zero_idle", busy, 0);
`else
      repeat (3) step();
      chk("zero_red_valid", cmd_valid, 1);
      chk("zero_red_type", cmd_type, 4);
      chk("zero_red_data", cmd_data, 0);
      chk("zero_no_err", err, 0);
`endif
      drain();

      // Asynchronous reset during S_RED, then service restarts from pointer 0
      set_req(2, 1'b0, 11, 22, 33);
      wait_grant(g, n);
      chk("rst_mid_grant", g, 2);
      repeat (3) step();
      chk("rst_mid_in_red", cmd_type, 4);
      #2;
      arstn_i   = 1'b0;
      drv_arstn = 1'b0;
      #1;
      chk("rst_mid_valid_drop", cmd_valid, 0);
      chk("rst_mid_busy_drop", busy, 0);
      sched.delete();
      mptr = 0;
      mgid = 0;
      acc  = '0;
      set_req(0, 1'b0, 4, 5, 6);
      set_req(3, 1'b0, 7, 8, 9);
      repeat (2) step();
      drv_arstn = 1'b1;
      wait_grant(g, n);
      chk("rst_restart_ptr0", g, 0);
      drv_valid = '0;
      drain();

      // Randomised traffic against the model
      rnd_en = 1'b1;
      repeat (3000) step();
      rnd_en    = 1'b0;
      drv_valid = '0;
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/traffic_cmd_arbiter.md
# traffic_cmd_arbiter

Shares the single command port of one `traffic_lights` instance between `N_REQ` independent requesters, such as a maintenance console, a timetable scheduler and an emergency override. Each requester submits a complete configuration transaction: new green/red/yellow times, or a switch-off. The block arbitrates round-robin and replays each granted transaction to `traffic_lights` as a fixed burst of single-cycle commands. The block sits directly in front of `traffic_lights`; its `cmd_*_o` outputs connect 1:1 to that block's `cmd_*_i` inputs.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters; range 2..16.
- `DATA_W`, 16: width of the time fields in ms; matches `cmd_data_i` of `traffic_lights`.
- `GAP_CYCLES`, 2: idle cycles forced after every burst; minimum 1.

Ports:
- `clk_i` input 1: single clock.
- `arstn_i` input 1: reset, asynchronous, active-low.
- `req_valid_i` input `N_REQ`: a requester has a transaction pending.
- `req_ready_o` output `N_REQ`: one-hot, one-cycle grant/accept pulse.
- `req_off_i` input `N_REQ`: transaction is OFF only; the time fields are ignored.
- `req_green_ms_i` input `N_REQ` x `DATA_W`: green time per requester.
- `req_red_ms_i` input `N_REQ` x `DATA_W`: red time per requester.
- `req_yellow_ms_i` input `N_REQ` x `DATA_W`: yellow time per requester.
- `cmd_type_o` output 3: command to `traffic_lights`.
- `cmd_valid_o` output 1: command strobe.
- `cmd_data_o` output `DATA_W`: command payload.
- `busy_o` output 1: high in every state except IDLE.
- `grant_id_o` output `$clog2(N_REQ)`: index of the last granted requester.
- `err_o` output 1: one-cycle rejection pulse (see Configuration).

## Operation
- Command codes:
  - ON = 3'b000
  - OFF = 3'b001
  - NOTRANS = 3'b010
  - SET_GREEN = 3'b011
  - SET_RED = 3'b100
  - SET_YELLOW = 3'b101
- FSM states: IDLE, S_NOTRANS, S_GREEN, S_RED, S_YELLOW, S_ON, S_OFF, GAP.
- In IDLE, the round-robin arbiter picks the first asserted `req_valid_i` at or after pointer `ptr`. The pick is combinational: `req_ready_o[g]` = 1 in that same cycle.
- On that clock edge:
  - the requester's fields are latched into internal registers;
  - `grant_id_o` <= g;
  - `ptr` <= (g+1) mod `N_REQ`.
- The FSM then moves to S_OFF if the latched off flag is set, otherwise to S_NOTRANS.
- Configuration burst: S_NOTRANS -> S_GREEN -> S_RED -> S_YELLOW -> S_ON -> GAP.
- OFF burst: S_OFF -> GAP.
- Each S_* state drives `cmd_valid_o` = 1 for exactly one cycle, with `cmd_type_o` set to its code.
- `cmd_data_o` carries:
  - the latched green, red or yellow value in S_GREEN, S_RED and S_YELLOW;
  - 0 in every other state.
- GAP holds `cmd_valid_o` = 0 for `GAP_CYCLES` cycles, then the FSM returns to IDLE. A down-counter of width `$clog2(GAP_CYCLES+1)` sets the length.
- Requests are sampled only in IDLE. A requester must hold valid and its fields until it sees ready. A request dropped before ready is simply never served; there is no error.
- Time values pass through unmodified; no arithmetic is applied. The ms-to-tick conversion is done by `traffic_lights`.
- All `cmd_*_o` are registered outputs.

## Timing
- Reset (`arstn_i` = 0) asynchronously forces:
  - FSM to IDLE;
  - `ptr` = 0;
  - `cmd_valid_o`, `cmd_type_o`, `cmd_data_o` = 0;
  - `req_ready_o` = 0;
  - `busy_o` = 0, `grant_id_o` = 0, `err_o` = 0.
- Reset mid-burst aborts the burst at once. Remaining commands are never issued and the requester is not re-served.
- Grant at cycle t gives:
  - NOTRANS at t+1, SET_GREEN at t+2, SET_RED at t+3, SET_YELLOW at t+4, ON at t+5;
  - IDLE again at t+6+`GAP_CYCLES`.
- Grant at cycle t of an OFF request gives OFF at t+1 and IDLE at t+2+`GAP_CYCLES`.
- Minimum request-to-request spacing is 6+`GAP_CYCLES` cycles (config) or 2+`GAP_CYCLES` cycles (off).
- Simultaneous valids are served in rotating order starting from `ptr`. With all valid and `ptr` = 0, the order is 0, 1, 2, 3, 0, ...
- `req_ready_o` is never asserted outside IDLE. It is never asserted for more than one requester per cycle.

## Configuration
- Macro: `TL_CMD_ZERO_REJECT_EN`.
- Defined: a configuration request whose green, red or yellow field is 0 is still accepted. The block then pulses `err_o` for one cycle at t+1, issues no commands, and moves straight to GAP. OFF requests are never rejected.
- Undefined: `err_o` is tied to 0 and zero values are issued as-is.

## Structure
- Package `traffic_cmd_pkg`:
  - `cmd_type_t` enum holding the six command codes;
  - `TL_DATA_W` = 16;
  - FSM state enum `tl_arb_state_t`.
  - Shared with `traffic_lights` and its benches.
- Sub-module `rr_arbiter` (parameter `N`): inputs req vector and `ptr`; outputs one-hot grant and binary index. Purely combinational; `ptr` lives in the parent.

## Test plan
- Single request 0 with green=30, red=50, yellow=100 -> cycles t+1..t+5 show types 010, 011/30, 100/50, 101/100, 000. `busy_o` returns low at t+6+`GAP_CYCLES`.
- All 4 requesters valid continuously -> grants in order 0, 1, 2, 3, 0. Each grant is 6+`GAP_CYCLES` = 8 cycles apart. `grant_id_o` follows.
- Requester 2 with `req_off_i` = 1 -> a single OFF (001) at t+1, no other commands; the next grant is possible at t+4.
- `arstn_i` low during S_RED -> `cmd_valid_o` drops without a clock edge. After release, a new request is served from `ptr` = 0.
- With `TL_CMD_ZERO_REJECT_EN`, request red=0 -> `err_o` is 1 for one cycle, zero `cmd_valid_o` pulses, then IDLE. Without the macro, the full burst is issued with SET_RED data 0.
- The bench connects `traffic_lights`, issues config 50/100/30 ms, and checks the red/yellow/green output durations match the programmed times.
